// File: rtl/spi_pkg.sv
// Shared types for the SPI-attached RAM: command opcodes carried in din[9:8]
// and the command-flow FSM states.
package spi_pkg;

  localparam int unsigned CMD_W  = 10;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT_RD = 2'b01,
    TX_HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// Synchronous byte array with one write port and one registered read port.
// Out-of-range writes are dropped and out-of-range reads return zero. The
// read register is reset so the read data is zero while reset is asserted;
// the array itself is never reset, so its contents survive a reset.
module spi_ram_mem
  import spi_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic [ADDR_SIZE-1:0] i_waddr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic                 i_re,
  input  logic [ADDR_SIZE-1:0] i_raddr,
  output logic [DATA_W-1:0]    o_rdata
);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              w_waddr_ok;
  logic              w_raddr_ok;

  assign w_waddr_ok = 32'(i_waddr) < MEM_DEPTH;
  assign w_raddr_ok = 32'(i_raddr) < MEM_DEPTH;

  // Array write; no reset so contents are retained across reset
  always_ff @(posedge clk) begin
    if (i_we && w_waddr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read; holds its value between read strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= w_raddr_ok ? r_mem[i_raddr] : '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram.sv
// Command decoder and FSM for a RAM driven by an SPI slave front end.
// din[9:8] selects WR_ADDR / WR_DATA / RD_ADDR / RD_DATA; RD_DATA returns a
// byte on dout one cycle later with tx_valid held until the next command.
// Optional build macro SPI_RAM_AUTOINC_EN: post-increment wr_addr after each
// accepted WR_DATA and rd_addr after each RD_DATA, wrapping at MEM_DEPTH-1.
module spi_ram
  import spi_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CMD_W-1:0]  din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid
);

  opcode_e              w_op;
  logic                 w_cmd_wr_addr;
  logic                 w_cmd_wr_data;
  logic                 w_cmd_rd_addr;
  logic                 w_cmd_rd_data;
  logic                 w_mem_we;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic [ADDR_SIZE-1:0] w_wr_addr_nxt;
  logic [ADDR_SIZE-1:0] w_rd_addr_nxt;
  state_e               r_state;
  state_e               w_state_nxt;
  logic [DATA_W-1:0]    w_mem_rdata;

`ifdef SPI_RAM_AUTOINC_EN
  function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
    if (32'(a) >= MEM_DEPTH - 1) begin
      return '0;
    end
    return a + ADDR_SIZE'(1);
  endfunction
`endif

  assign w_op          = opcode_e'(din[9:8]);
  assign w_cmd_wr_addr = rx_valid && (w_op == WR_ADDR);
  assign w_cmd_wr_data = rx_valid && (w_op == WR_DATA);
  assign w_cmd_rd_addr = rx_valid && (w_op == RD_ADDR);
  assign w_cmd_rd_data = rx_valid && (w_op == RD_DATA);
  // A write is accepted only when it lands inside the array
  assign w_mem_we      = w_cmd_wr_data && (32'(r_wr_addr) < MEM_DEPTH);

  // Next write/read address pointers; the two are updated independently
  always_comb begin
    w_wr_addr_nxt = r_wr_addr;
    w_rd_addr_nxt = r_rd_addr;
    if (w_cmd_wr_addr) begin
      w_wr_addr_nxt = din[ADDR_SIZE-1:0];
    end
    if (w_cmd_rd_addr) begin
      w_rd_addr_nxt = din[ADDR_SIZE-1:0];
    end
`ifdef SPI_RAM_AUTOINC_EN
    if (w_mem_we) begin
      w_wr_addr_nxt = addr_inc(r_wr_addr);
    end
    if (w_cmd_rd_data) begin
      w_rd_addr_nxt = addr_inc(r_rd_addr);
    end
`endif
  end

  // Address pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
    end else begin
      r_wr_addr <= w_wr_addr_nxt;
      r_rd_addr <= w_rd_addr_nxt;
    end
  end

  // FSM state register; reset drops tx_valid asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; RD_DATA is serviced from any state
  always_comb begin
    w_state_nxt = r_state;
    if (rx_valid) begin
      unique case (r_state)
        IDLE: begin
          if (w_cmd_rd_addr) begin
            w_state_nxt = WAIT_RD;
          end else if (w_cmd_rd_data) begin
            w_state_nxt = TX_HOLD;
          end
        end
        WAIT_RD: begin
          if (w_cmd_rd_data) begin
            w_state_nxt = TX_HOLD;
          end
        end
        TX_HOLD: begin
          if (!w_cmd_rd_data) begin
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  spi_ram_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_addr),
    .i_wdata (din[DATA_W-1:0]),
    .i_re    (w_cmd_rd_data),
    .i_raddr (r_rd_addr),
    .o_rdata (w_mem_rdata)
  );

  assign dout     = w_mem_rdata;
  assign tx_valid = (r_state == TX_HOLD);

endmodule

// File: tb/tb_spi_ram.sv
// Directed bench for spi_ram: a full-size instance (MEM_DEPTH=256) and a
// reduced instance (MEM_DEPTH=200) share the same command stream.
module tb_spi_ram;

  logic       clk;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic [7:0] dout_s;
  logic       tx_valid_s;

  int n_tests;
  int n_fail;

  spi_ram #(
    .MEM_DEPTH (256),
    .ADDR_SIZE (8)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid)
  );

  spi_ram #(
    .MEM_DEPTH (200),
    .ADDR_SIZE (8)
  ) u_dut_small (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout_s),
    .tx_valid (tx_valid_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents one command for the following posedge and
  // returns at the next negedge, so consecutive calls are back-to-back.
  task automatic cmd(input logic [9:0] d);
    din      = d;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    din      = 10'h000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    din      = 10'h000;
    rx_valid = 1'b0;
    idle(2);
    check("rst_dout", 16'(dout), 16'h00);
    check("rst_tx", 16'(tx_valid), 16'h0);
    check("rst_tx_small", 16'(tx_valid_s), 16'h0);
    rst_n = 1'b1;

    // Basic write then read of address 0x0A
    cmd(10'h00A);
    cmd(10'h155);
    check("wr_no_tx", 16'(tx_valid), 16'h0);
    cmd(10'h20A);
    cmd(10'h300);
    check("rd_0a_dout", 16'(dout), 16'h55);
    check("rd_0a_tx", 16'(tx_valid), 16'h1);
    idle(3);
    check("hold_dout", 16'(dout), 16'h55);
    check("hold_tx", 16'(tx_valid), 16'h1);

    // Any non-read command ends the hold; then back-to-back write/read
    cmd(10'h005);
    check("hold_clear_tx", 16'(tx_valid), 16'h0);
    cmd(10'h1AA);
    cmd(10'h205);
    cmd(10'h300);
    check("b2b_dout", 16'(dout), 16'hAA);
    check("b2b_tx", 16'(tx_valid), 16'h1);

    // RD_ADDR during hold returns to idle; RD_DATA from idle still reads
    cmd(10'h20A);
    check("rdaddr_clear_tx", 16'(tx_valid), 16'h0);
    cmd(10'h300);
    check("rd_idle_dout", 16'(dout), 16'h55);
`ifndef SPI_RAM_AUTOINC_EN
    cmd(10'h300);
    check("rd_again_dout", 16'(dout), 16'h55);
    check("rd_again_tx", 16'(tx_valid), 16'h1);
`endif

    // Write/read pointers are independent
    cmd(10'h00C);
    cmd(10'h1C3);
    cmd(10'h20A);
    cmd(10'h300);
    check("indep_rd_0a", 16'(dout), 16'h55);
    cmd(10'h20C);
    cmd(10'h300);
    check("rd_0c", 16'(dout), 16'hC3);
    cmd(10'h205);
    cmd(10'h300);
    check("rd_05_kept", 16'(dout), 16'hAA);

    // Address 0xF0 is in range for 256 entries, out of range for 200
    cmd(10'h0F0);
    cmd(10'h1FF);
    cmd(10'h2F0);
    cmd(10'h300);
    check("f0_dout", 16'(dout), 16'hFF);
    check("oor_dout", 16'(dout_s), 16'h00);
    check("oor_tx", 16'(tx_valid_s), 16'h1);

    // din without rx_valid is ignored
    din = 10'h0FF;
    idle(1);
    din = 10'h000;
    check("novalid_dout", 16'(dout), 16'hFF);
    check("novalid_tx", 16'(tx_valid), 16'h1);

`ifdef SPI_RAM_AUTOINC_EN
    cmd(10'h0FF);
    cmd(10'h111);
    cmd(10'h122);
    cmd(10'h2FF);
    cmd(10'h300);
    check("inc_ff", 16'(dout), 16'h11);
    cmd(10'h300);
    check("inc_wrap_00", 16'(dout), 16'h22);
`else
    cmd(10'h0FF);
    cmd(10'h111);
    cmd(10'h122);
    cmd(10'h2FF);
    cmd(10'h300);
    check("noinc_ff", 16'(dout), 16'h22);
`endif

    // Reset during hold clears outputs without a clock edge
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", 16'(tx_valid), 16'h0);
    check("async_rst_dout", 16'(dout), 16'h00);
    check("async_rst_tx_small", 16'(tx_valid_s), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cmd(10'h20C);
    cmd(10'h300);
    check("post_rst_mem", 16'(dout), 16'hC3);
    // wr_addr came out of reset at 0
    cmd(10'h15A);
    cmd(10'h200);
    cmd(10'h300);
    check("post_rst_wr0", 16'(dout), 16'h5A);
    check("post_rst_tx", 16'(tx_valid), 16'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
